// File: rtl/poly_addsub_ctrl_pkg.sv
// Shared constants and FSM encoding for the Kyber coefficient-wise add/sub sequencer.
package poly_addsub_ctrl_pkg;

   localparam int KYBER_Q = 3329;
   localparam int KYBER_N = 256;
   localparam int COEFF_W = 12;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/poly_addsub_ctrl_mod_addsub.sv
// Combinational modular add/sub of two coefficients in [0,Q-1]; result also in [0,Q-1].
module mod_addsub
   import poly_addsub_ctrl_pkg::*;
#(
   parameter int Q = KYBER_Q
) (
   input  logic [COEFF_W-1:0] a,
   input  logic [COEFF_W-1:0] b,
   input  logic               op,
   output logic [COEFF_W-1:0] c
);

   localparam logic [COEFF_W:0] Q_EXT = (COEFF_W + 1)'(Q);

   logic [COEFF_W:0] sum;
   logic [COEFF_W:0] diff;

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      sum  = {1'b0, a} + {1'b0, b};
      diff = {1'b0, a} - {1'b0, b};
      c    = '0;
      if (op == OP_SUB) begin
         // diff[COEFF_W] is the sign of A-B; a single +Q brings it back into range
         c = diff[COEFF_W] ? COEFF_W'(diff + Q_EXT) : diff[COEFF_W-1:0];
      end else begin
         c = (sum >= Q_EXT) ? COEFF_W'(sum - Q_EXT) : sum[COEFF_W-1:0];
      end
   end

endmodule

// File: rtl/poly_addsub_ctrl.sv
// Streams N coefficient pairs from two source RAMs through mod_addsub into a result RAM,
// one polynomial operation per accepted start pulse.
module poly_addsub_ctrl
   import poly_addsub_ctrl_pkg::*;
#(
   parameter int Q      = KYBER_Q,
   parameter int N      = KYBER_N,
   parameter int AW     = 8,
   parameter int RD_LAT = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               op,
   output logic               busy,
   output logic               done,
   output logic               rd_en,
   output logic [AW-1:0]      rd_addr,
   input  logic [COEFF_W-1:0] a_data,
   input  logic [COEFF_W-1:0] b_data,
   output logic               wr_en,
   output logic [AW-1:0]      wr_addr,
   output logic [COEFF_W-1:0] wr_data
);

   localparam logic [AW-1:0] LAST = AW'(N - 1);

   state_t             state;
   state_t             state_next;
   logic               op_q;
   logic [RD_LAT-1:0]  pipe_vld;
   logic [AW-1:0]      pipe_addr [RD_LAT];
   logic [COEFF_W-1:0] result;

   mod_addsub #(.Q(Q)) u_mod_addsub (
      .a  (a_data),
      .b  (b_data),
      .op (op_q),
      .c  (result)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      busy       = (state != ST_IDLE);
      done       = (state == ST_DONE);
      unique case (state)
         ST_IDLE:  if (start) state_next = ST_RUN;
         ST_RUN:   if (rd_addr == LAST) state_next = ST_DRAIN;
         ST_DRAIN: if (wr_en && wr_addr == LAST) state_next = ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Read address counter; it parks at N-1 and is re-armed by the next accepted start.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_en   <= 1'b0;
         rd_addr <= '0;
         op_q    <= OP_ADD;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  rd_en   <= 1'b1;
                  rd_addr <= '0;
                  op_q    <= op;
               end
            end
            ST_RUN: begin
               if (rd_addr == LAST) rd_en <= 1'b0;
               else                 rd_addr <= rd_addr + AW'(1);
            end
            default: ;
         endcase
      end
   end

   // Valid bits track each read until its data lands; clearing them on reset cancels writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_vld <= '0;
      end else begin
         pipe_vld[0] <= rd_en;
         for (int i = 1; i < RD_LAT; i++) pipe_vld[i] <= pipe_vld[i-1];
      end
   end

   // NOTE: the address stages are not reset; they are only consumed when their valid bit is set.
   always_ff @(posedge clk) begin
      pipe_addr[0] <= rd_addr;
      for (int i = 1; i < RD_LAT; i++) pipe_addr[i] <= pipe_addr[i-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         wr_en <= pipe_vld[RD_LAT-1];
         if (pipe_vld[RD_LAT-1]) begin
            wr_addr <= pipe_addr[RD_LAT-1];
            wr_data <= result;
         end
      end
   end

endmodule

// File: tb/tb_poly_addsub_ctrl.sv
// Bench for poly_addsub_ctrl: two instances (RD_LAT=1 and 2) share stimulus and RAM contents;
// a per-cycle operation model checks every output, and literal expectations pin key results.
module tb_poly_addsub_ctrl;

   localparam int Q = 3329;
   localparam int N = 256;

   logic clk;
   logic rst;
   logic start;
   logic op;

   logic [11:0] mem_a [N];
   logic [11:0] mem_b [N];

   int n_tests = 0;
   int n_fail  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(int lat, string name, int got, int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL lat%0d %s: got %0d, expected %0d (t=%0t)", lat, name, got, exp, $time);
      end
   endtask

   function automatic int expect_coeff(int a, int b, bit o);
      if (o) return (a - b + Q) % Q;
      return (a + b) % Q;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : lane
      localparam int LAT = g + 1;

      logic        busy, done, rd_en, wr_en;
      logic [7:0]  rd_addr, wr_addr;
      logic [11:0] a_data, b_data, wr_data;
      logic [11:0] ram_a [LAT];
      logic [11:0] ram_b [LAT];
      logic [11:0] res [N];

      int cyc     = 0;
      int t0      = 0;
      int seen_t0 = -1;
      int nwr     = 0;
      int ndone   = 0;
      int first_r = -1;
      int last_r  = -1;
      int done_r  = -1;
      bit active  = 1'b0;
      bit fresh   = 1'b0;
      bit op_m    = 1'b0;

      poly_addsub_ctrl #(.RD_LAT(LAT)) dut (
         .clk     (clk),
         .rst     (rst),
         .start   (start),
         .op      (op),
         .busy    (busy),
         .done    (done),
         .rd_en   (rd_en),
         .rd_addr (rd_addr),
         .a_data  (a_data),
         .b_data  (b_data),
         .wr_en   (wr_en),
         .wr_addr (wr_addr),
         .wr_data (wr_data)
      );

      // Source RAMs with LAT cycles of read latency
      always @(posedge clk) begin
         ram_a[0] <= mem_a[rd_addr];
         ram_b[0] <= mem_b[rd_addr];
         for (int i = 1; i < LAT; i++) begin
            ram_a[i] <= ram_a[i-1];
            ram_b[i] <= ram_b[i-1];
         end
      end
      assign a_data = ram_a[LAT-1];
      assign b_data = ram_b[LAT-1];

      // Operation model: which cycle the current operation started in, and whether one is live
      always @(posedge clk) begin
         if (rst) begin
            active <= 1'b0;
            fresh  <= 1'b1;
         end else if (active) begin
            if (cyc - t0 == N + 2 + LAT) active <= 1'b0;
         end else if (start) begin
            active <= 1'b1;
            fresh  <= 1'b0;
            t0     <= cyc;
            op_m   <= op;
         end
         cyc <= cyc + 1;
      end

      always @(negedge clk) begin
         int  r;
         int  k;
         bit  e_rd;
         bit  e_wr;
         r    = cyc - t0;
         e_rd = active && r <= N;
         e_wr = active && r >= LAT + 2 && r <= N + 1 + LAT;
         if (active && t0 != seen_t0) begin
            seen_t0 = t0;
            nwr     = 0;
            first_r = -1;
            last_r  = -1;
         end
         check(LAT, "busy",  busy,  active);
         check(LAT, "done",  done,  active && r == N + 2 + LAT);
         check(LAT, "rd_en", rd_en, e_rd);
         check(LAT, "wr_en", wr_en, e_wr);
         if (e_rd) check(LAT, "rd_addr", rd_addr, r - 1);
         if (e_wr) begin
            k = r - 2 - LAT;
            check(LAT, "wr_addr", wr_addr, k);
            check(LAT, "wr_data", wr_data, expect_coeff(mem_a[k], mem_b[k], op_m));
         end
         if (fresh && !active) begin
            check(LAT, "rst_rd_addr", rd_addr, 0);
            check(LAT, "rst_wr_addr", wr_addr, 0);
            check(LAT, "rst_wr_data", wr_data, 0);
         end
         if (wr_en) begin
            res[wr_addr] = wr_data;
            nwr++;
            if (first_r < 0) first_r = r;
            last_r = r;
         end
         if (done) begin
            ndone++;
            done_r = r;
         end
      end
   end

   task automatic pulse_start(bit o);
      @(posedge clk); #1;
      op    = o;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_cycles(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_full_run(int ndone_exp);
      check(1, "ndone",   lane[0].ndone,   ndone_exp);
      check(2, "ndone",   lane[1].ndone,   ndone_exp);
      check(1, "nwr",     lane[0].nwr,     256);
      check(2, "nwr",     lane[1].nwr,     256);
      check(1, "first_wr", lane[0].first_r, 3);
      check(1, "last_wr",  lane[0].last_r,  258);
      check(1, "done_at",  lane[0].done_r,  259);
      check(2, "first_wr", lane[1].first_r, 4);
      check(2, "last_wr",  lane[1].last_r,  259);
      check(2, "done_at",  lane[1].done_r,  260);
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      op    = 1'b0;
      for (int k = 0; k < N; k++) begin
         mem_a[k] = 12'(k);
         mem_b[k] = 12'(k + 1);
      end
      wait_cycles(3);
      rst = 1'b0;
      wait_cycles(2);

      // add A[k]=k, B[k]=k+1, with a second start at cycle 100 that must be ignored
      pulse_start(1'b0);
      wait_cycles(98);
      start = 1'b1;
      wait_cycles(1);
      start = 1'b0;
      wait_cycles(200);
      check_full_run(1);
      for (int g = 0; g < 2; g++) begin
         check(g + 1, "add_res0",   (g == 0) ? lane[0].res[0]   : lane[1].res[0],   1);
         check(g + 1, "add_res100", (g == 0) ? lane[0].res[100] : lane[1].res[100], 201);
         check(g + 1, "add_res255", (g == 0) ? lane[0].res[255] : lane[1].res[255], 511);
      end

      // sub 0-1 wraps to Q-1 everywhere; op is flipped mid-operation and must not matter
      for (int k = 0; k < N; k++) begin
         mem_a[k] = 12'd0;
         mem_b[k] = 12'd1;
      end
      pulse_start(1'b1);
      wait_cycles(20);
      op = 1'b0;
      wait_cycles(260);
      check_full_run(2);
      check(1, "sub_res0",   lane[0].res[0],   3328);
      check(1, "sub_res255", lane[0].res[255], 3328);
      check(2, "sub_res0",   lane[1].res[0],   3328);
      check(2, "sub_res255", lane[1].res[255], 3328);

      // boundary pairs at addresses 0..3, the rest random in range
      for (int k = 0; k < N; k++) begin
         mem_a[k] = 12'($urandom_range(Q - 1));
         mem_b[k] = 12'($urandom_range(Q - 1));
      end
      mem_a[0] = 12'd3328; mem_b[0] = 12'd1;
      mem_a[1] = 12'd3328; mem_b[1] = 12'd3328;
      mem_a[2] = 12'd5;    mem_b[2] = 12'd5;
      mem_a[3] = 12'd0;    mem_b[3] = 12'd3328;
      pulse_start(1'b0);
      wait_cycles(270);
      check_full_run(3);
      check(1, "add_3328_1",    lane[0].res[0], 0);
      check(1, "add_3328_3328", lane[0].res[1], 3327);
      check(2, "add_3328_1",    lane[1].res[0], 0);
      check(2, "add_3328_3328", lane[1].res[1], 3327);
      pulse_start(1'b1);
      wait_cycles(270);
      check_full_run(4);
      check(1, "sub_5_5",    lane[0].res[2], 0);
      check(1, "sub_0_3328", lane[0].res[3], 1);
      check(2, "sub_5_5",    lane[1].res[2], 0);
      check(2, "sub_0_3328", lane[1].res[3], 1);

      // reset during cycle 50 of an operation: writes stop, done never pulses
      pulse_start(1'b0);
      wait_cycles(49);
      rst = 1'b1;
      wait_cycles(1);
      rst = 1'b0;
      wait_cycles(300);
      check(1, "abort_ndone", lane[0].ndone, 4);
      check(2, "abort_ndone", lane[1].ndone, 4);
      check(1, "abort_nwr",   lane[0].nwr,   48);
      check(2, "abort_nwr",   lane[1].nwr,   47);
      check(1, "abort_busy",  lane[0].busy,  0);
      check(2, "abort_busy",  lane[1].busy,  0);

      // reset and start together: reset wins
      @(posedge clk); #1;
      rst   = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      rst   = 1'b0;
      start = 1'b0;
      wait_cycles(5);
      check(1, "rst_start_busy", lane[0].busy, 0);
      check(2, "rst_start_busy", lane[1].busy, 0);

      // fresh run after the aborted one
      for (int k = 0; k < N; k++) begin
         mem_a[k] = 12'(k);
         mem_b[k] = 12'(k + 1);
      end
      pulse_start(1'b0);
      wait_cycles(270);
      check_full_run(5);
      check(1, "rerun_res10", lane[0].res[10], 21);
      check(2, "rerun_res10", lane[1].res[10], 21);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
